// File: rtl/inst_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : inst_ram_arbiter
//  Brief    : Shares single-port inst_ram between CPU fetch and loader/debug;
//             loader-only BOOT phase, then round-robin RUN phase.
//  Revision : 1.0  initial release
// ============================================================================
module inst_ram_arbiter #(
    parameter int AW            = 16,
    parameter int DW            = 32,
    parameter int CW            = 16,
    parameter bit START_IN_BOOT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          boot_done,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [DW-1:0] fetch_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_spo,
    output logic          in_boot,
    output logic [CW-1:0] wr_count
);

    localparam logic [0:0] c_st_boot    = 1'b0;
    localparam logic [0:0] c_st_run     = 1'b1;
    localparam logic       c_own_fetch  = 1'b0;
    localparam logic       c_own_loader = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          r_last_owner;
    logic          r_rsp_valid;
    logic          r_rsp_owner;
    logic [CW-1:0] r_wr_count;
    logic          w_fetch_gnt;
    logic          w_ld_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= START_IN_BOOT ? c_st_boot : c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == c_st_boot) && boot_done) begin
            w_state_nxt = c_st_run;
        end
    end

    // Fetch is locked out in BOOT; in RUN a conflict goes to whoever was not last served.
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_ld_gnt    = 1'b0;
        if (!reset) begin
            if (r_state == c_st_boot) begin
                w_ld_gnt = ld_req;
            end else if (fetch_req && ld_req) begin
                if (r_last_owner == c_own_loader) begin
                    w_fetch_gnt = 1'b1;
                end else begin
                    w_ld_gnt = 1'b1;
                end
            end else begin
                w_fetch_gnt = fetch_req;
                w_ld_gnt    = ld_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_owner  <= c_own_loader;
            r_last_owner <= c_own_loader;
            r_wr_count   <= '0;
        end else begin
            r_rsp_valid <= w_fetch_gnt | (w_ld_gnt & ~ld_we);
            r_rsp_owner <= w_ld_gnt ? c_own_loader : c_own_fetch;
            if (w_fetch_gnt || w_ld_gnt) begin
                r_last_owner <= w_ld_gnt ? c_own_loader : c_own_fetch;
            end
            if (w_ld_gnt && ld_we && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + CW'(1);
            end
        end
    end

    assign fetch_gnt = w_fetch_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign ram_a     = w_ld_gnt ? ld_addr : fetch_addr;
    assign ram_d     = ld_wdata;
    assign ram_we    = w_ld_gnt & ld_we;

    // Masking with reset drops the response of a read granted just before reset.
    assign fetch_rvalid = r_rsp_valid & (r_rsp_owner == c_own_fetch) & ~reset;
    assign ld_rvalid    = r_rsp_valid & (r_rsp_owner == c_own_loader) & ~reset;
    assign fetch_rdata  = ram_spo;
    assign ld_rdata     = ram_spo;

    assign in_boot  = (r_state == c_st_boot);
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_ram_arbiter
//  Brief    : Directed and randomized bench for inst_ram_arbiter against a
//             cycle-level behavioural model with a shadow memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_ram_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int MAXW = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, boot_done;
    logic          fetch_req, ld_req, ld_we;
    logic [AW-1:0] fetch_addr, ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          fetch_gnt, fetch_rvalid, ld_gnt, ld_rvalid, ram_we, in_boot;
    logic [DW-1:0] fetch_rdata, ld_rdata, ram_d;
    logic [DW-1:0] ram_spo;
    logic [AW-1:0] ram_a;
    logic [CW-1:0] wr_count;

    always #5 clk = ~clk;

    inst_ram_arbiter #(
        .AW(AW), .DW(DW), .CW(CW), .START_IN_BOOT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .boot_done(boot_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo),
        .in_boot(in_boot), .wr_count(wr_count)
    );

    // Synchronous single-port RAM with registered read port.
    bit [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_a[7:0]] <= ram_d;
        ram_spo <= ram_mem[ram_a[7:0]];
    end

    int          tests = 0;
    int          fails = 0;
    bit          m_known = 1'b0, m_boot = 1'b1, m_last_fetch = 1'b0;
    bit          m_pv = 1'b0, m_pf = 1'b0;
    logic [DW-1:0] m_pd = '0;
    int          m_wr = 0;
    bit [DW-1:0] shadow [256];
    bit          e_fg, e_lg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cyc(input bit r, input bit bd, input bit fr, input logic [AW-1:0] fa,
                       input bit lr, input bit lw, input logic [AW-1:0] la,
                       input logic [DW-1:0] lwd);
        @(negedge clk);
        reset = r; boot_done = bd;
        fetch_req = fr; fetch_addr = fa;
        ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd;
        #1;
        e_fg = 1'b0; e_lg = 1'b0;
        if (!r) begin
            if (m_boot)          e_lg = lr;
            else if (fr && lr) begin
                if (m_last_fetch) e_lg = 1'b1;
                else              e_fg = 1'b1;
            end else begin
                e_fg = fr; e_lg = lr;
            end
        end
        check("fetch_gnt", fetch_gnt, e_fg);
        check("ld_gnt", ld_gnt, e_lg);
        check("ram_we", ram_we, e_lg && lw);
        if (e_lg)      check("ram_a_ld", ram_a, la);
        else if (e_fg) check("ram_a_fetch", ram_a, fa);
        if (e_lg && lw) check("ram_d", ram_d, lwd);
        check("fetch_rvalid", fetch_rvalid, !r && m_pv && m_pf);
        check("ld_rvalid", ld_rvalid, !r && m_pv && !m_pf);
        if (!r && m_pv && m_pf)  check("fetch_rdata", fetch_rdata, m_pd);
        if (!r && m_pv && !m_pf) check("ld_rdata", ld_rdata, m_pd);
        if (m_known) begin
            check("in_boot", in_boot, m_boot);
            check("wr_count", wr_count, m_wr);
        end
        if (r) begin
            m_known = 1'b1; m_boot = 1'b1; m_last_fetch = 1'b0; m_pv = 1'b0; m_wr = 0;
        end else begin
            m_pv = e_fg || (e_lg && !lw);
            m_pf = e_fg;
            if (e_fg)              m_pd = shadow[fa[7:0]];
            else if (e_lg && !lw)  m_pd = shadow[la[7:0]];
            if (e_fg || e_lg)      m_last_fetch = e_fg;
            if (e_lg && lw) begin
                shadow[la[7:0]] = lwd;
                if (m_wr < MAXW) m_wr++;
            end
            if (m_boot && bd) m_boot = 1'b0;
        end
    endtask

    logic [DW-1:0] boot_data [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    bit            rr, rbd, rfr, rlr, rlw, prev_rst;
    logic [AW-1:0] rfa, rla;
    logic [DW-1:0] rwd;

    initial begin
        reset = 1'b1; boot_done = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;

        // Reset for two cycles, then an idle cycle to see the reset state.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_in_boot", in_boot, 1'b1);
        check("reset_wr_count", wr_count, 0);

        // BOOT: loader fills words 0..3 while fetch is held off.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 2, 1, 1, AW'(i), boot_data[i]);
        cyc(0, 1, 1, 2, 0, 0, 0, 0);
        check("boot_wr_count", wr_count, 4);

        // RUN: fetch reads word 2.
        cyc(0, 0, 1, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("run_fetch_rdata", fetch_rdata, 32'h33333333);

        // Both requesting every cycle: grants alternate.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1, 0, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Write then immediate read-back of the same word.
        cyc(0, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF);
        cyc(0, 0, 1, 5, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("wr_rd_fetch_rdata", fetch_rdata, 32'hDEADBEEF);

        // Reset right after a granted fetch swallows its response.
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_in_boot", in_boot, 1'b1);
        check("post_rst_wr_count", wr_count, 0);

        // Randomized traffic; un-granted requests are held stable.
        rfr = 1'b0; rlr = 1'b0; rfa = '0; rla = '0; rlw = 1'b0; rwd = '0; prev_rst = 1'b0;
        e_fg = 1'b0; e_lg = 1'b0;
        for (int n = 0; n < 500; n++) begin
            rr  = ($urandom_range(0, 149) == 0);
            rbd = ($urandom_range(0, 7) == 0);
            if (!rfr || e_fg || prev_rst) begin
                rfr = $urandom_range(0, 1);
                rfa = AW'($urandom_range(0, 15));
            end
            if (!rlr || e_lg || prev_rst) begin
                rlr = $urandom_range(0, 1);
                rlw = $urandom_range(0, 1);
                rla = AW'($urandom_range(0, 15));
                rwd = $urandom;
            end
            cyc(rr, rbd, rfr, rfa, rlr, rlw, rla, rwd);
            prev_rst = rr;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
